cnn_layer_accel_wht_seq_ctrl: RTL and testbench
===============================================

CNN_LAYER_ACCEL_WHT_SEQ_CTRL -- requirements
Module: cnn_layer_accel_wht_seq_ctrl

Interface
REQ-001 SHALL have parameter C_NUM_PIX_WIDTH, default 16, width of the pixels-per-kernel count.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- job_start  in  1  pulse; begins a job.
- num_kernels  in  16  kernel count minus 1, sampled on accepted job_start.
- num_pixels  in  C_NUM_PIX_WIDTH  pixels per kernel minus 1, sampled on accepted job_start.
- wht_in_valid / wht_in_ready  in / out  1  weight stream handshake.
- wht_in_data  in  16  weight word.
- exec_start  in  1  pulse; begins execution after configuration.
- exec_stall  in  1  freezes execution sequencing.
- config_mode, job_accept, kernel_config_valid  out  1  weight table control.
- num_kernels_out  out  16  registered, saturated kernel count.
- wht_config_wren  out  1 / wht_config_data  out  16  table write port.
- wht_seq_addr0, wht_seq_addr1  out  4  per-beat weight slot indices.
- ce_execute  out  1 / ce_cycle_counter  out  3  beat valid / beat index.
- next_kernel  out  1  kernel-advance pulse.
- busy, done, cfg_err  out  1  status.

Function
REQ-003 SHALL implement FSM IDLE -> CFG_LOAD <-> CFG_PAD -> CFG_DONE -> EXEC -> DONE -> IDLE.
REQ-004 In IDLE, job_start SHALL be accepted; job_start in any other state SHALL be ignored.
REQ-005 Accepted job_start at cycle t SHALL produce one-cycle job_accept and kernel_config_valid pulses at t+1, with config_mode high from t+1.
REQ-006 num_kernels above 63 SHALL saturate num_kernels_out to 63 and set cfg_err until the next accepted job_start.
REQ-007 In CFG_LOAD, wht_in_ready SHALL be 1.
REQ-008 Each valid&&ready beat SHALL produce, one cycle later, wht_config_wren=1 and wht_config_data=wht_in_data.
REQ-009 After the 9th accepted word of a kernel, the FSM SHALL enter CFG_PAD for exactly one cycle with wht_in_ready=0.
REQ-010 CFG_PAD SHALL produce one write with wht_config_data=0 (slot 9 zero pad), giving 10 slots per kernel.
REQ-011 After the pad write for kernel num_kernels_out, the FSM SHALL go to CFG_DONE.
REQ-012 In CFG_DONE, config_mode SHALL drop to 0 and the FSM SHALL wait for exec_start.
REQ-013 exec_start outside CFG_DONE SHALL be ignored.
REQ-014 EXEC SHALL issue 5 beats per pixel: ce_execute=1, ce_cycle_counter=i, wht_seq_addr0=2i, wht_seq_addr1=2i+1, for i=0..4.
REQ-015 The first beat SHALL be issued the cycle after exec_start.
REQ-016 While exec_stall=1, ce_execute SHALL be 0 and all counters and addresses SHALL hold; sequencing SHALL resume with the held beat.
REQ-017 After beat 4 of pixel num_pixels, next_kernel SHALL pulse one cycle and the pixel counter SHALL clear.
REQ-018 After the last kernel's final beat, the FSM SHALL go to DONE, which pulses done for one cycle and then returns to IDLE.
REQ-019 num_kernels=0 SHALL mean one kernel and num_pixels=0 SHALL mean one pixel; the configuration and execution counts SHALL follow from this with no other special-casing.
REQ-020 Counters SHALL be sized so that num_pixels=2^C_NUM_PIX_WIDTH-1 does not wrap early.
REQ-021 busy SHALL be 1 in every state except IDLE.

Reset
REQ-022 During rst, all outputs SHALL be 0, the FSM SHALL be in IDLE, and counters, cfg_err and sampled registers SHALL be 0.
REQ-023 rst asserted mid-CFG or mid-EXEC SHALL abort in the next cycle with no further wren, ce_execute or next_kernel.

Structure
REQ-024 The FSM state enum and the constants WHT_PER_KERNEL=9, WHT_SLOTS_PER_KERNEL=10, BEATS_PER_PIXEL=5 and MAX_KERNEL_IDX=63 SHALL reside in a shared package, cnn_layer_accel_pkg.
REQ-025 The beat/pixel/kernel nested counter SHALL be one sub-module, cnn_layer_accel_exec_cntr, with a stall-hold input and terminal-count outputs.

Verification
REQ-026 num_kernels=0 with 9 words streamed back-to-back -> 10 writes, the 10th with data 0; wht_in_ready low exactly 1 cycle; config_mode drops after the pad.
REQ-027 num_kernels=1, num_pixels=1, exec_start -> 20 beats with address pairs (0,1)(2,3)(4,5)(6,7)(8,9) repeated; next_kernel after beats 10 and 20; done 1 cycle after the final next_kernel.
REQ-028 exec_stall high for 3 cycles during beat 2 -> ce_execute=0 for 3 cycles, then beat 2 reissued with addresses (4,5).
REQ-029 num_kernels=100 -> num_kernels_out=63, cfg_err=1, 640 config writes.
REQ-030 rst mid-EXEC at beat 3 -> all outputs 0 the next cycle; a following job_start is accepted normally.
REQ-031 job_start during EXEC and exec_start during CFG_LOAD -> both ignored; no change to state or counters.

Source files
------------

// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator weight sequencing.
package cnn_layer_accel_pkg;

  // Weights loaded per kernel; one zero pad slot follows them in the table.
  localparam int WHT_PER_KERNEL       = 9;
  localparam int WHT_SLOTS_PER_KERNEL = 10;
  // Each pixel consumes the ten slots as five address pairs.
  localparam int BEATS_PER_PIXEL      = 5;
  // Highest kernel index the weight table can hold.
  localparam int MAX_KERNEL_IDX       = 63;

  localparam int DATA_W = 16;
  localparam int KERN_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_LOAD,
    ST_CFG_PAD,
    ST_CFG_DONE,
    ST_EXEC,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/cnn_layer_accel_exec_cntr.sv
// Beat / pixel / kernel nested counter for execution sequencing.
// Advances one beat per cycle while run is high and hold is low.
module cnn_layer_accel_exec_cntr
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_NUM_PIX_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       run,
  input  logic                       hold,
  input  logic [C_NUM_PIX_WIDTH-1:0] pix_last,
  input  logic [KERN_W-1:0]          kern_last,
  output logic [2:0]                 beat,
  output logic                       kern_end,
  output logic                       job_end
);

  logic [C_NUM_PIX_WIDTH-1:0] pix;
  logic [KERN_W-1:0]          kern;
  logic                       beat_end;

  // Pixel counter is as wide as the configured limit, so the all-ones limit
  // is reached before the counter can wrap.
  assign beat_end = (beat == 3'(BEATS_PER_PIXEL - 1));
  assign kern_end = beat_end && (pix == pix_last);
  assign job_end  = kern_end && (kern == kern_last);

  // Nested count: beat fastest, then pixel, then kernel; frozen under hold.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beat <= '0;
      pix  <= '0;
      kern <= '0;
    end else if (run && !hold) begin
      if (beat_end) begin
        beat <= '0;
        if (pix == pix_last) begin
          pix <= '0;
          if (kern == kern_last) begin
            kern <= '0;
          end else begin
            kern <= kern + KERN_W'(1);
          end
        end else begin
          pix <= pix + C_NUM_PIX_WIDTH'(1);
        end
      end else begin
        beat <= beat + 3'd1;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_wht_seq_ctrl.sv
// Weight table sequencer: loads kernel weights (plus a zero pad slot) into
// the weight table, then walks the table as address pairs per pixel beat.
module cnn_layer_accel_wht_seq_ctrl
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_NUM_PIX_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_start,
  input  logic [15:0]                num_kernels,
  input  logic [C_NUM_PIX_WIDTH-1:0] num_pixels,
  input  logic                       wht_in_valid,
  output logic                       wht_in_ready,
  input  logic [15:0]                wht_in_data,
  input  logic                       exec_start,
  input  logic                       exec_stall,
  output logic                       config_mode,
  output logic                       job_accept,
  output logic                       kernel_config_valid,
  output logic [15:0]                num_kernels_out,
  output logic                       wht_config_wren,
  output logic [15:0]                wht_config_data,
  output logic [3:0]                 wht_seq_addr0,
  output logic [3:0]                 wht_seq_addr1,
  output logic                       ce_execute,
  output logic [2:0]                 ce_cycle_counter,
  output logic                       next_kernel,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  seq_state_t state, state_nxt;

  logic [KERN_W-1:0]          kern_last;
  logic [C_NUM_PIX_WIDTH-1:0] pix_last;
  logic [3:0]                 cfg_word;
  logic [KERN_W-1:0]          cfg_kern;
  logic                       cfg_err_r;

  logic                       job_acc_p1;
  logic                       wren_p1;
  logic [DATA_W-1:0]          wdata_p1;
  logic                       next_kernel_p1;
  logic                       fin_p1;

  logic                       job_go;
  logic                       wht_beat;
  logic                       exec_run;
  logic                       beat_go;
  logic                       exec_clr;
  logic [2:0]                 beat;
  logic                       kern_end;
  logic                       job_end;

  // Clamp the requested kernel index to what the weight table can hold.
  function automatic logic [KERN_W-1:0] sat_kernel_idx(input logic [15:0] n);
    if (n > 16'(MAX_KERNEL_IDX)) begin
      return KERN_W'(MAX_KERNEL_IDX);
    end
    return n[KERN_W-1:0];
  endfunction

  assign job_go   = (state == ST_IDLE) && job_start;
  assign wht_beat = (state == ST_CFG_LOAD) && wht_in_valid;
  // fin_p1 marks the cycle after the final beat; no beats issue there.
  assign exec_run = (state == ST_EXEC) && !fin_p1;
  assign beat_go  = exec_run && !exec_stall;
  assign exec_clr = (state != ST_EXEC);

  cnn_layer_accel_exec_cntr #(
    .C_NUM_PIX_WIDTH(C_NUM_PIX_WIDTH)
  ) u_exec_cntr (
    .clk      (clk),
    .rst      (rst),
    .clr      (exec_clr),
    .run      (exec_run),
    .hold     (exec_stall),
    .pix_last (pix_last),
    .kern_last(kern_last),
    .beat     (beat),
    .kern_end (kern_end),
    .job_end  (job_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    config_mode  = 1'b0;
    wht_in_ready = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (job_start) state_nxt = ST_CFG_LOAD;
      end
      ST_CFG_LOAD: begin
        config_mode  = 1'b1;
        wht_in_ready = 1'b1;
        if (wht_in_valid && (cfg_word == 4'(WHT_PER_KERNEL - 1))) state_nxt = ST_CFG_PAD;
      end
      ST_CFG_PAD: begin
        config_mode = 1'b1;
        state_nxt   = (cfg_kern == kern_last) ? ST_CFG_DONE : ST_CFG_LOAD;
      end
      ST_CFG_DONE: begin
        if (exec_start) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (fin_p1) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Job parameters captured on accept, and configuration word/kernel counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      kern_last <= '0;
      pix_last  <= '0;
      cfg_err_r <= 1'b0;
      cfg_word  <= '0;
      cfg_kern  <= '0;
    end else if (job_go) begin
      kern_last <= sat_kernel_idx(num_kernels);
      pix_last  <= num_pixels;
      cfg_err_r <= (num_kernels > 16'(MAX_KERNEL_IDX));
      cfg_word  <= '0;
      cfg_kern  <= '0;
    end else begin
      if (wht_beat) begin
        cfg_word <= (cfg_word == 4'(WHT_PER_KERNEL - 1)) ? 4'd0 : cfg_word + 4'd1;
      end
      if ((state == ST_CFG_PAD) && (cfg_kern != kern_last)) begin
        cfg_kern <= cfg_kern + KERN_W'(1);
      end
    end
  end

  // ---- stage p0 -> p1: registered pulses and table write port ----
  // Pad slot is written with zero during the single CFG_PAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_acc_p1     <= 1'b0;
      wren_p1        <= 1'b0;
      wdata_p1       <= '0;
      next_kernel_p1 <= 1'b0;
      fin_p1         <= 1'b0;
    end else begin
      job_acc_p1     <= job_go;
      wren_p1        <= wht_beat || (state == ST_CFG_PAD);
      wdata_p1       <= wht_beat ? wht_in_data : '0;
      next_kernel_p1 <= beat_go && kern_end;
      fin_p1         <= beat_go && job_end;
    end
  end

  assign job_accept          = job_acc_p1;
  assign kernel_config_valid = job_acc_p1;
  assign num_kernels_out     = {{(16 - KERN_W){1'b0}}, kern_last};
  assign cfg_err             = cfg_err_r;
  assign wht_config_wren     = wren_p1;
  assign wht_config_data     = wdata_p1;
  assign next_kernel         = next_kernel_p1;
  assign ce_execute          = beat_go;
  // Beat index and address pair hold through a stall; zero outside execution.
  assign ce_cycle_counter    = exec_run ? beat : 3'd0;
  assign wht_seq_addr0       = exec_run ? {beat, 1'b0} : 4'd0;
  assign wht_seq_addr1       = exec_run ? {beat, 1'b1} : 4'd0;

endmodule

// File: tb/tb_cnn_layer_accel_wht_seq_ctrl.sv
// Bench for the weight table sequencer: vector table, hand-written corner
// sequences and randomized jobs against a queue-based reference model.
module tb_cnn_layer_accel_wht_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_start;
  logic [15:0] num_kernels;
  logic [15:0] num_pixels;
  logic        wht_in_valid;
  logic        wht_in_ready;
  logic [15:0] wht_in_data;
  logic        exec_start;
  logic        exec_stall;
  logic        config_mode, job_accept, kernel_config_valid;
  logic [15:0] num_kernels_out;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic [3:0]  wht_seq_addr0, wht_seq_addr1;
  logic        ce_execute;
  logic [2:0]  ce_cycle_counter;
  logic        next_kernel, busy, done, cfg_err;
  logic [52:0] all_out;

  always #5 clk = ~clk;

  cnn_layer_accel_wht_seq_ctrl #(.C_NUM_PIX_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .num_kernels(num_kernels),
    .num_pixels(num_pixels), .wht_in_valid(wht_in_valid), .wht_in_ready(wht_in_ready),
    .wht_in_data(wht_in_data), .exec_start(exec_start), .exec_stall(exec_stall),
    .config_mode(config_mode), .job_accept(job_accept),
    .kernel_config_valid(kernel_config_valid), .num_kernels_out(num_kernels_out),
    .wht_config_wren(wht_config_wren), .wht_config_data(wht_config_data),
    .wht_seq_addr0(wht_seq_addr0), .wht_seq_addr1(wht_seq_addr1),
    .ce_execute(ce_execute), .ce_cycle_counter(ce_cycle_counter),
    .next_kernel(next_kernel), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  assign all_out = {config_mode, job_accept, kernel_config_valid, num_kernels_out,
                    wht_config_wren, wht_config_data, wht_seq_addr0, wht_seq_addr1,
                    ce_execute, ce_cycle_counter, next_kernel, busy, done, cfg_err,
                    wht_in_ready};

  typedef struct {
    logic [15:0] nk;
    logic [15:0] np;
    int          exp_nko;
    int          exp_err;
    int          exp_wr;
    int          exp_beats;
    int          exp_nk;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed-event log, filled by the monitor while mon_en is high.
  bit          mon_en = 1'b0;
  int          cyc = 0;
  logic [15:0] wr_q[$];
  logic [10:0] beat_q[$];
  int          nk_at[$];
  int          nk_cyc[$];
  int          done_cyc[$];
  int          beat_cnt, ja_cnt, pad_cnt, viol;
  logic [15:0] sent_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!mon_en) begin
      wr_q.delete(); beat_q.delete(); nk_at.delete(); nk_cyc.delete(); done_cyc.delete();
      beat_cnt = 0; ja_cnt = 0; pad_cnt = 0; viol = 0;
    end else begin
      if (wht_config_wren) wr_q.push_back(wht_config_data);
      if (next_kernel) begin nk_at.push_back(beat_cnt); nk_cyc.push_back(cyc); end
      if (ce_execute) begin
        beat_q.push_back({ce_cycle_counter, wht_seq_addr0, wht_seq_addr1});
        beat_cnt++;
      end
      if (done) done_cyc.push_back(cyc);
      if (job_accept) ja_cnt++;
      if (config_mode && !wht_in_ready) pad_cnt++;
      if (ce_execute && exec_stall) viol++;
    end
  end

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] k, input logic [15:0] p);
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    sent_q.delete();
    mon_en = 1'b1;
    tick();
    num_kernels = k;
    num_pixels  = p;
    job_start   = 1'b1;
    tick();
    job_start   = 1'b0;
  endtask

  task automatic cfg_phase(input int vpct);
    bit fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      wht_in_valid = ($urandom_range(99) < vpct);
      wht_in_data  = 16'($urandom);
      @(negedge clk);
      if (!config_mode) fin = 1'b1;
      else begin
        if (wht_in_valid && wht_in_ready) sent_q.push_back(wht_in_data);
        tick();
      end
    end
    wht_in_valid = 1'b0;
    check_eq("cfg_phase_completes", fin, 1);
  endtask

  task automatic exec_wait(input int spct);
    bit fin = 1'b0;
    for (int c = 0; c < 8000 && !fin; c++) begin
      exec_stall = ($urandom_range(99) < spct);
      @(negedge clk);
      if (done) fin = 1'b1;
      else tick();
    end
    exec_stall = 1'b0;
    tick();
    tick();
    check_eq("exec_phase_completes", fin, 1);
  endtask

  task automatic exec_phase(input int spct);
    tick();
    exec_start = 1'b1;
    tick();
    exec_start = 1'b0;
    exec_wait(spct);
  endtask

  task automatic run_job(input logic [15:0] k, input logic [15:0] p, input int vpct, input int spct);
    start_job(k, p);
    cfg_phase(vpct);
    exec_phase(spct);
  endtask

  // Reference model: every kernel takes 9 streamed words then a zero pad;
  // execution visits every (kernel, pixel, beat) with addresses 2i, 2i+1.
  task automatic check_job(input logic [15:0] k, input logic [15:0] p);
    logic [15:0] exp_w[$];
    logic [10:0] exp_b[$];
    int          exp_nk[$];
    int          kn, pn, bad;
    kn = (k > 16'd63) ? 64 : int'(k) + 1;
    pn = int'(p) + 1;
    check_eq("sent_words", sent_q.size(), 9 * kn);
    foreach (sent_q[i]) begin
      exp_w.push_back(sent_q[i]);
      if (i % 9 == 8) exp_w.push_back(16'h0000);
    end
    check_eq("write_count", wr_q.size(), 10 * kn);
    bad = -1;
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      if (bad < 0 && wr_q[i] !== exp_w[i]) bad = i;
    check_eq("write_data_first_bad_index", bad, -1);
    for (int kk = 0; kk < kn; kk++) begin
      for (int pp = 0; pp < pn; pp++)
        for (int i = 0; i < 5; i++) exp_b.push_back({3'(i), 4'(2 * i), 4'(2 * i + 1)});
      exp_nk.push_back((kk + 1) * pn * 5);
    end
    check_eq("beat_count", beat_q.size(), exp_b.size());
    bad = -1;
    for (int i = 0; i < exp_b.size() && i < beat_q.size(); i++)
      if (bad < 0 && beat_q[i] !== exp_b[i]) bad = i;
    check_eq("beat_seq_first_bad_index", bad, -1);
    check_eq("next_kernel_count", nk_at.size(), kn);
    bad = -1;
    for (int i = 0; i < exp_nk.size() && i < nk_at.size(); i++)
      if (bad < 0 && nk_at[i] != exp_nk[i]) bad = i;
    check_eq("next_kernel_position_first_bad_index", bad, -1);
    check_eq("done_pulses", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && nk_cyc.size() > 0)
      check_eq("done_after_last_next_kernel", done_cyc[0] - nk_cyc[nk_cyc.size() - 1], 1);
    check_eq("num_kernels_out", num_kernels_out, kn - 1);
    check_eq("cfg_err", cfg_err, longint'(k > 16'd63));
    check_eq("job_accept_pulses", ja_cnt, 1);
    check_eq("ready_low_cycles_in_config", pad_cnt, kn);
    check_eq("execute_during_stall", viol, 0);
  endtask

  vec_t vecs[6];

  initial begin
    bit found;
    logic [15:0] rk, rp;

    vecs[0] = '{16'd0,   16'd0, 0,  0, 10,  5,   1};
    vecs[1] = '{16'd100, 16'd0, 63, 1, 640, 320, 64};
    vecs[2] = '{16'd3,   16'd2, 3,  0, 40,  60,  4};
    vecs[3] = '{16'd64,  16'd0, 63, 1, 640, 320, 64};
    vecs[4] = '{16'd63,  16'd1, 63, 0, 640, 640, 64};
    vecs[5] = '{16'd7,   16'd3, 7,  0, 80,  160, 8};

    rst = 1'b1; job_start = 1'b0; num_kernels = '0; num_pixels = '0;
    wht_in_valid = 1'b0; wht_in_data = '0; exec_start = 1'b0; exec_stall = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("reset_outputs_zero", all_out, 0);
    tick();
    rst = 1'b0;

    // Single kernel, back-to-back words, pad write and config_mode drop.
    start_job(16'd0, 16'd0);
    wht_in_valid = 1'b1;
    wht_in_data  = 16'hA000;
    @(negedge clk);
    check_eq("job_accept_t1", job_accept, 1);
    check_eq("kernel_config_valid_t1", kernel_config_valid, 1);
    check_eq("config_mode_t1", config_mode, 1);
    check_eq("busy_t1", busy, 1);
    sent_q.push_back(wht_in_data);
    tick();
    for (int i = 1; i < 9; i++) begin
      wht_in_data = 16'hA000 + 16'(i);
      @(negedge clk);
      if (wht_in_ready) sent_q.push_back(wht_in_data);
      tick();
    end
    wht_in_data = 16'hDEAD;
    @(negedge clk);
    check_eq("pad_ready_low", wht_in_ready, 0);
    check_eq("pad_config_mode_high", config_mode, 1);
    check_eq("ninth_write_data", wht_config_data, 16'hA008);
    check_eq("job_accept_one_cycle", job_accept, 0);
    tick();
    wht_in_valid = 1'b0;
    @(negedge clk);
    check_eq("config_mode_dropped", config_mode, 0);
    check_eq("pad_write_en", wht_config_wren, 1);
    check_eq("pad_write_data", wht_config_data, 0);
    exec_phase(0);
    check_job(16'd0, 16'd0);

    // Two kernels, two pixels: ignored exec_start/job_start, stall on beat 2.
    start_job(16'd1, 16'd1);
    exec_start   = 1'b1;
    wht_in_valid = 1'b1;
    wht_in_data  = 16'h5A5A;
    @(negedge clk);
    check_eq("exec_start_in_cfg_ignored", {config_mode, wht_in_ready, ce_execute}, 3'b110);
    sent_q.push_back(wht_in_data);
    tick();
    exec_start = 1'b0;
    cfg_phase(100);
    tick();
    @(negedge clk);
    check_eq("waiting_for_exec_start", {busy, config_mode, ce_execute}, 3'b100);
    tick();
    exec_start = 1'b1;
    tick();
    exec_start = 1'b0;
    @(negedge clk);
    check_eq("first_beat", {ce_execute, ce_cycle_counter, wht_seq_addr0, wht_seq_addr1},
             {1'b1, 3'd0, 4'd0, 4'd1});
    tick();
    @(negedge clk);
    check_eq("second_beat_index", ce_cycle_counter, 1);
    tick();
    exec_stall  = 1'b1;
    num_kernels = 16'd50;
    job_start   = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_eq("stall_ce_low", ce_execute, 0);
      check_eq("stall_holds_addr", {wht_seq_addr0, wht_seq_addr1}, 8'h45);
      tick();
      job_start = 1'b0;
    end
    exec_stall = 1'b0;
    @(negedge clk);
    check_eq("beat2_reissued", {ce_execute, ce_cycle_counter, wht_seq_addr0, wht_seq_addr1},
             {1'b1, 3'd2, 4'd4, 4'd5});
    check_eq("job_start_in_exec_ignored", {job_accept, num_kernels_out}, 17'd1);
    tick();
    exec_wait(0);
    check_job(16'd1, 16'd1);

    // Reset during execution at beat 3, then a normal job.
    start_job(16'd0, 16'd2);
    cfg_phase(100);
    exec_phase_start: begin
      tick();
      exec_start = 1'b1;
      tick();
      exec_start = 1'b0;
    end
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (ce_execute && ce_cycle_counter == 3'd3) found = 1'b1;
      else tick();
    end
    check_eq("beat3_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_exec_outputs_zero", all_out, 0);
    @(negedge clk);
    check_eq("rst_held_outputs_zero", all_out, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("idle_after_abort", all_out, 0);
    end
    run_job(16'd2, 16'd0, 100, 0);
    check_job(16'd2, 16'd0);

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v].nk, vecs[v].np, 75, 25);
      check_eq("vec_num_kernels_out", num_kernels_out, vecs[v].exp_nko);
      check_eq("vec_cfg_err", cfg_err, vecs[v].exp_err);
      check_eq("vec_writes", wr_q.size(), vecs[v].exp_wr);
      check_eq("vec_beats", beat_q.size(), vecs[v].exp_beats);
      check_eq("vec_next_kernels", nk_at.size(), vecs[v].exp_nk);
      check_eq("vec_done", done_cyc.size(), 1);
      check_job(vecs[v].nk, vecs[v].np);
    end

    // Randomized jobs.
    for (int r = 0; r < 6; r++) begin
      rk = ($urandom_range(3) == 0) ? 16'(64 + $urandom_range(200)) : 16'($urandom_range(7));
      rp = 16'($urandom_range(3));
      run_job(rk, rp, 40 + $urandom_range(60), $urandom_range(50));
      check_job(rk, rp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
